// File: rtl/serial_word_assembler.sv
// serial_word_assembler: collects an MSB-first serial bit stream into an
// N-bit word and presents it on word/load for one cycle, ready for a
// downstream load/store register to capture.
//
// Optional feature macro: PARITY_CHECK_EN
//   undefined (default): no parity stage; frame_err is held at 0.
//   defined: after the N data bits, one further valid bit carries even
//            parity. A good frame loads the word. A bad frame pulses
//            frame_err for one cycle, does not load, and leaves word as it was.
module serial_word_assembler #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         start,
  input  logic         abort,
  input  logic         bit_in,
  input  logic         bit_valid,
  output logic [N-1:0] word,
  output logic         load,
  output logic         busy,
  output logic         frame_err
);

  // Bit counter must be able to hold the value N.
  localparam int unsigned CW = $clog2(N + 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DONE   = 2'd2,
    PARITY = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
`endif

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic [N-1:0]  shreg;
  logic [N-1:0]  shreg_nx;
  logic [N-1:0]  word_nx;
  logic          load_nx;
  logic          busy_nx;
  logic          frame_err_nx;

  // Shift register contents once the current bit has been accepted.
  logic [N-1:0]  shifted;
  // High while the bit being accepted is the final data bit of the frame.
  logic          last_bit;

  assign shifted  = {shreg[N-2:0], bit_in};
  assign last_bit = (count == CW'(N - 1));

  // State and output registers; reset drops any partial frame immediately.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      count     <= '0;
      shreg     <= '0;
      word      <= '0;
      load      <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      shreg     <= shreg_nx;
      word      <= word_nx;
      load      <= load_nx;
      busy      <= busy_nx;
      frame_err <= frame_err_nx;
    end
  end

  // Next-state and next-output logic; abort outranks bit_valid and start.
  always_comb begin
    state_nx     = state;
    count_nx     = count;
    shreg_nx     = shreg;
    word_nx      = word;
    load_nx      = 1'b0;
    frame_err_nx = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nx = SHIFT;
          count_nx = '0;
          shreg_nx = '0;
        end
      end

      SHIFT: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (bit_valid) begin
          shreg_nx = shifted;
          count_nx = count + CW'(1);
          if (last_bit) begin
`ifdef PARITY_CHECK_EN
            state_nx = PARITY;
`else
            state_nx = DONE;
            word_nx  = shifted;
            load_nx  = 1'b1;
`endif
          end
        end
      end

`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (bit_valid) begin
          if ((^shreg ^ bit_in) == 1'b0) begin
            state_nx = DONE;
            word_nx  = shreg;
            load_nx  = 1'b1;
          end else begin
            state_nx     = IDLE;
            frame_err_nx = 1'b1;
          end
        end
      end
`endif

      DONE: begin
        // A held start chains straight into the next frame.
        if (start && !abort) begin
          state_nx = SHIFT;
          count_nx = '0;
          shreg_nx = '0;
        end else begin
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

`ifdef PARITY_CHECK_EN
    busy_nx = (state_nx == SHIFT) || (state_nx == PARITY);
`else
    busy_nx = (state_nx == SHIFT);
`endif
  end

endmodule

// File: tb/tb_serial_word_assembler.sv
// tb_serial_word_assembler: directed checks of serial_word_assembler with N=8.
// Frame-timing tests cover the default build; parity tests run only when
// PARITY_CHECK_EN is defined.
module tb_serial_word_assembler;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         clear_n;
  logic         start;
  logic         abort;
  logic         bit_in;
  logic         bit_valid;
  logic [N-1:0] word;
  logic         load;
  logic         busy;
  logic         frame_err;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  always #5 clk = ~clk;

  serial_word_assembler #(.N(N)) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .start     (start),
    .abort     (abort),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .word      (word),
    .load      (load),
    .busy      (busy),
    .frame_err (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [7:0]  v;
    int unsigned busy_n;
    int unsigned t0;
    int unsigned t1;

    clear_n   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    tick();
    tick();
    check("rst_word", 32'(word), 32'h0);
    check("rst_load", 32'(load), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    clear_n = 1'b1;
    tick();

`ifndef PARITY_CHECK_EN
    // Test 1: 0xA5 back-to-back bits; load the cycle after bit 8.
    v = 8'hA5;
    start_frame();
    busy_n = 32'(busy);
    for (int i = 0; i < 8; i++) begin
      send_bit(v[7-i]);
      if (i < 7) begin
        check("t1_noload", 32'(load), 32'h0);
        busy_n += 32'(busy);
      end
    end
    check("t1_load", 32'(load), 32'h1);
    check("t1_word", 32'(word), 32'hA5);
    check("t1_busy_end", 32'(busy), 32'h0);
    check("t1_busy_cycles", busy_n, 32'd8);
    check("t1_ferr", 32'(frame_err), 32'h0);
    tick();
    check("t1_load_drop", 32'(load), 32'h0);
    check("t1_word_hold", 32'(word), 32'hA5);

    // Test 2: 3-cycle gap between bits 3 and 4 delays load by 3.
    t0 = cyc;
    start_frame();
    for (int i = 0; i < 3; i++) send_bit(v[7-i]);
    for (int g = 0; g < 3; g++) begin
      tick();
      check("t2_gap_load", 32'(load), 32'h0);
      check("t2_gap_busy", 32'(busy), 32'h1);
    end
    for (int i = 3; i < 8; i++) send_bit(v[7-i]);
    check("t2_load", 32'(load), 32'h1);
    check("t2_latency", cyc - t0, 32'd12);
    check("t2_word", 32'(word), 32'hA5);
    tick();

    // Test 3: 0x3C completes, next frame aborted after 4 bits.
    v = 8'h3C;
    start_frame();
    for (int i = 0; i < 8; i++) send_bit(v[7-i]);
    check("t3_load", 32'(load), 32'h1);
    check("t3_word", 32'(word), 32'h3C);
    tick();
    v = 8'h5A;
    start_frame();
    for (int i = 0; i < 4; i++) send_bit(v[7-i]);
    check("t3_busy_pre", 32'(busy), 32'h1);
    abort     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    tick();
    abort     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    check("t3_abort_busy", 32'(busy), 32'h0);
    check("t3_abort_load", 32'(load), 32'h0);
    for (int i = 4; i < 8; i++) begin
      send_bit(v[7-i]);
      check("t3_after_load", 32'(load), 32'h0);
    end
    check("t3_word_kept", 32'(word), 32'h3C);
    check("t3_idle_busy", 32'(busy), 32'h0);

    // Test 4: start held through DONE chains a second frame 0x0F.
    v = 8'h3C;
    start = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) send_bit(v[7-i]);
    check("t4_load1", 32'(load), 32'h1);
    check("t4_word1", 32'(word), 32'h3C);
    t1 = cyc;
    tick();
    check("t4_done_load", 32'(load), 32'h0);
    check("t4_done_busy", 32'(busy), 32'h1);
    check("t4_done_word", 32'(word), 32'h3C);
    start = 1'b0;
    v = 8'h0F;
    for (int i = 0; i < 8; i++) send_bit(v[7-i]);
    check("t4_load2", 32'(load), 32'h1);
    check("t4_word2", 32'(word), 32'h0F);
    check("t4_spacing", cyc - t1, 32'd9);
    tick();
    check("t4_load_drop", 32'(load), 32'h0);

    // Test 5: asynchronous reset after bit 5; later bits need a new start.
    v = 8'hA5;
    start_frame();
    for (int i = 0; i < 5; i++) send_bit(v[7-i]);
    #2 clear_n = 1'b0;
    #1;
    check("t5_word", 32'(word), 32'h0);
    check("t5_load", 32'(load), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_ferr", 32'(frame_err), 32'h0);
    #2 clear_n = 1'b1;
    for (int i = 5; i < 8; i++) begin
      send_bit(v[7-i]);
      check("t5_ignored_busy", 32'(busy), 32'h0);
      check("t5_ignored_load", 32'(load), 32'h0);
    end
    check("t5_word_zero", 32'(word), 32'h0);
    v = 8'h5A;
    start_frame();
    for (int i = 0; i < 8; i++) send_bit(v[7-i]);
    check("t5_recover_load", 32'(load), 32'h1);
    check("t5_recover_word", 32'(word), 32'h5A);
    tick();
`else
    // Test 6: even parity; good frames load, a bad frame pulses frame_err.
    v = 8'hA5;
    start_frame();
    for (int i = 0; i < 8; i++) send_bit(v[7-i]);
    check("t6_wait_busy", 32'(busy), 32'h1);
    check("t6_wait_load", 32'(load), 32'h0);
    send_bit(1'b0);
    check("t6_good_load", 32'(load), 32'h1);
    check("t6_good_word", 32'(word), 32'hA5);
    check("t6_good_ferr", 32'(frame_err), 32'h0);
    tick();
    start_frame();
    for (int i = 0; i < 8; i++) send_bit(v[7-i]);
    send_bit(1'b1);
    check("t6_bad_ferr", 32'(frame_err), 32'h1);
    check("t6_bad_load", 32'(load), 32'h0);
    check("t6_bad_word", 32'(word), 32'hA5);
    check("t6_bad_busy", 32'(busy), 32'h0);
    tick();
    check("t6_ferr_drop", 32'(frame_err), 32'h0);
    v = 8'h07;
    start_frame();
    for (int i = 0; i < 8; i++) send_bit(v[7-i]);
    send_bit(1'b1);
    check("t6_odd_load", 32'(load), 32'h1);
    check("t6_odd_word", 32'(word), 32'h07);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
